// File: rtl/cep_printf_pkg.sv
// Shared constants and FSM state type for the printf mailbox writer.
package cep_printf_pkg;

    localparam int PRINTF_MAX_WORDS = 15;
    localparam int PRINTF_MAX_CHARS = 120;

    localparam logic [7:0] CHAR_NUL = 8'h00;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_CMD      = 3'd3,
        ST_WAIT_CLR = 3'd4
    } printf_state_t;

    function automatic logic is_terminator(input logic [7:0] c);
        return (c == CHAR_NUL) || (c == CHAR_LF);
    endfunction

endpackage

// File: rtl/printf_word_packer.sv
// Packs characters MSByte-first into a 64-bit word; flags word/string end combinationally
// on the accepting push. Caller must not push while a completed word awaits pop.
module printf_word_packer
    import cep_printf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  push_dat,
    input  logic        pop,
    output logic [63:0] word_dat,
    output logic [3:0]  word_idx,
    output logic        word_end,
    output logic        str_end
);

    logic [2:0] lane;
    logic [6:0] char_cnt;
    logic       last_char;

    assign last_char = is_terminator(push_dat) || (char_cnt == 7'(PRINTF_MAX_CHARS - 1));
    assign word_end  = push && ((lane == 3'd7) || last_char);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_dat <= '0;
            word_idx <= '0;
            lane     <= '0;
            char_cnt <= '0;
            str_end  <= 1'b0;
        end else if (push) begin
            // lane 0 lands in bits [63:56]
            word_dat[{~lane, 3'b111} -: 8] <= push_dat;
            lane     <= lane + 3'd1;
            char_cnt <= char_cnt + 7'd1;
            if (last_char)
                str_end <= 1'b1;
        end else if (pop) begin
            word_dat <= '0;
            lane     <= '0;
            if (!str_end && (word_idx != 4'(PRINTF_MAX_WORDS - 1)))
                word_idx <= word_idx + 4'd1;
        end
    end

endmodule

// File: rtl/printf_mailbox_writer.sv
// Streams a printf string into the scratchpad buffer word by word, then raises printf_cmd
// until the driver clears it; cmd rises 2 cycles after the terminator plus any mem_gnt stall.
module printf_mailbox_writer
    import cep_printf_pkg::*;
#(
    parameter logic [31:0] BUF_BASE     = 32'h8000_1000,
    parameter logic [1:0]  CORE_ID      = 2'd0,
    parameter logic [15:0] DONE_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_mask,
    input  logic        mem_gnt,
    output logic        printf_cmd,
    output logic [31:0] printf_addr,
    input  logic        printf_done,
    output logic        busy,
    output logic        err_timeout
);

    printf_state_t state, state_nxt;
    logic [15:0]   wait_cnt;
    logic          accept;
    logic          word_end;
    logic          str_end;
    logic          go_idle;
    logic          timed_out;
    logic [63:0]   word_dat;
    logic [3:0]    word_idx;

    assign char_ready = !rst && ((state == ST_IDLE) || (state == ST_FILL));
    assign accept     = char_valid && char_ready;
    assign timed_out  = (state == ST_WAIT_CLR) && !printf_done &&
                        (wait_cnt == DONE_TIMEOUT - 16'd1);

    printf_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (go_idle),
        .push     (accept),
        .push_dat (char_data),
        .pop      ((state == ST_WRITE) && mem_gnt),
        .word_dat (word_dat),
        .word_idx (word_idx),
        .word_end (word_end),
        .str_end  (str_end)
    );

    // A lone terminator accepted in IDLE already forms a complete word, so go straight to WRITE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = word_end ? ST_WRITE : ST_FILL;
            ST_FILL:     if (accept && word_end) state_nxt = ST_WRITE;
            ST_WRITE:    if (mem_gnt) state_nxt = str_end ? ST_CMD : ST_FILL;
            ST_CMD:      state_nxt = ST_WAIT_CLR;
            ST_WAIT_CLR: if (printf_done || timed_out) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign go_idle = (state != ST_IDLE) && (state_nxt == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ST_WAIT_CLR) ? wait_cnt + 16'd1 : 16'd0;
            if (timed_out)
                err_timeout <= 1'b1;
        end
    end

    assign mem_req     = (state == ST_WRITE);
    assign mem_addr    = mem_req ? BUF_BASE + {25'd0, word_idx, 3'b000} : 32'd0;
    assign mem_wdata   = mem_req ? word_dat : 64'd0;
    assign mem_mask    = mem_req ? 8'hFF : 8'h00;
    assign printf_cmd  = (state == ST_CMD) || (state == ST_WAIT_CLR);
    assign busy        = (state != ST_IDLE);
    assign printf_addr = BUF_BASE | {30'd0, CORE_ID};

endmodule

// File: tb/tb_printf_mailbox_writer.sv
// Randomized and directed bench for printf_mailbox_writer against a string-level model.
module tb_printf_mailbox_writer;

    localparam logic [31:0] BASE  = 32'h8000_1000;
    localparam int          TO    = 16;
    localparam int          LIMIT = 3000;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_gnt = 1'b0;
    logic        printf_cmd;
    logic [31:0] printf_addr;
    logic        printf_done = 1'b0;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    bit gnt_rand = 0, gnt_fix = 1, done_rand = 0, done_fix = 0;

    // model state
    wr_t         exp_q[$];
    wr_t         log_q[$];
    wr_t         w;
    int          nchars = 0;
    int          lane;
    int          cmd_age = 0;
    logic [63:0] wbuf = '0;
    bit          str_done = 0, cmd_phase = 0, str_active = 0, err_m = 0, exp_rdy;

    printf_mailbox_writer #(
        .BUF_BASE     (BASE),
        .CORE_ID      (2'd2),
        .DONE_TIMEOUT (16'(TO))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mask    (mem_mask),
        .mem_gnt     (mem_gnt),
        .printf_cmd  (printf_cmd),
        .printf_addr (printf_addr),
        .printf_done (printf_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        mem_gnt     = gnt_rand  ? ($urandom_range(0, 3) != 0) : gnt_fix;
        printf_done = done_rand ? ($urandom_range(0, 7) == 0) : done_fix;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_wait(input string name, input int waited);
        checks++;
        errors++;
        $display("FAIL %s: waited %0d cycles, limit %0d", name, waited, LIMIT);
    endtask

    // Compare + model advance: negedge values are exactly what the next posedge will sample.
    always @(negedge clk) begin
        if (rst) begin
            check("char_ready_in_rst", char_ready, 0);
            exp_q.delete();
            nchars = 0; wbuf = '0; cmd_age = 0;
            str_done = 0; cmd_phase = 0; str_active = 0; err_m = 0;
        end else begin
            exp_rdy = (exp_q.size() == 0) && !cmd_phase;
            check("char_ready", char_ready, exp_rdy);
            if (exp_q.size() > 0) begin
                w = exp_q[0];
                check("mem_req", mem_req, 1);
                check("mem_addr", mem_addr, w.addr);
                check("mem_wdata", mem_wdata, w.data);
                check("mem_mask", mem_mask, 8'hFF);
            end else begin
                check("mem_req_idle", mem_req, 0);
                check("mem_addr_idle", mem_addr, 0);
                check("mem_wdata_idle", mem_wdata, 0);
                check("mem_mask_idle", mem_mask, 0);
            end
            check("printf_cmd", printf_cmd, cmd_phase);
            check("busy", busy, str_active);
            check("err_timeout", err_timeout, err_m);
            check("printf_addr", printf_addr, 32'h8000_1002);
            if (mem_req && mem_gnt) begin
                w.addr = mem_addr; w.data = mem_wdata;
                log_q.push_back(w);
            end

            if (cmd_phase) begin
                // age 0 is the first flag cycle, where done is not yet looked at
                if (cmd_age >= 1 && printf_done) begin
                    cmd_phase = 0; str_active = 0;
                end else if (cmd_age == TO) begin
                    cmd_phase = 0; str_active = 0; err_m = 1;
                end else begin
                    cmd_age++;
                end
            end else if (exp_q.size() > 0) begin
                if (mem_gnt) begin
                    w = exp_q.pop_front();
                    if (str_done) begin
                        cmd_phase = 1; cmd_age = 0; str_done = 0; nchars = 0;
                    end
                end
            end else if (char_valid) begin
                lane = nchars % 8;
                str_active = 1;
                wbuf = wbuf | ({56'd0, char_data} << (8 * (7 - lane)));
                nchars++;
                if (char_data == 8'h00 || char_data == 8'h0A || nchars == 120)
                    str_done = 1;
                if (lane == 7 || str_done) begin
                    w.addr = BASE + 32'(8 * ((nchars - 1) / 8));
                    w.data = wbuf;
                    exp_q.push_back(w);
                    wbuf = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        char_valid = 1'b1;
        char_data  = c;
        n = 0;
        while (!char_ready && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) fail_wait("send_char", n);
        tick();
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (!printf_cmd && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) fail_wait("wait_cmd", n);
    endtask

    task automatic release_cmd();
        int n;
        done_fix = 1;
        n = 0;
        while (printf_cmd && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) fail_wait("release_cmd", n);
        done_fix = 0;
        tick();
    endtask

    initial begin
        int n;
        logic [7:0] c;
        rst = 1'b1; char_valid = 1'b0; char_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_char_ready", char_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_printf_cmd", printf_cmd, 0);
        check("rst_err", err_timeout, 0);

        // "Hi\n": cmd appears 2 cycles after the acceptance cycle, i.e. one edge after send returns
        log_q.delete();
        send_str("Hi\n");
        wait_cmd(n);
        check("hi_cmd_latency", n, 1);
        check("hi_writes", log_q.size(), 1);
        check("hi_addr", log_q[0].addr, 32'h8000_1000);
        check("hi_data", log_q[0].data, 64'h4869_0A00_0000_0000);
        repeat (3) tick();
        check("hi_cmd_held", printf_cmd, 1);
        check("hi_printf_addr", printf_addr, 32'h8000_1002);
        release_cmd();
        check("hi_idle", busy, 0);

        log_q.delete();
        send_str("ABCDEFGHIJ");
        send_char(8'h00);
        wait_cmd(n);
        check("abc_writes", log_q.size(), 2);
        check("abc_data0", log_q[0].data, 64'h4142_4344_4546_4748);
        check("abc_addr1", log_q[1].addr, 32'h8000_1008);
        check("abc_data1", log_q[1].data, 64'h494A_0000_0000_0000);
        release_cmd();

        log_q.delete();
        for (int i = 0; i < 120; i++) send_char(8'h41);
        check("full_rdy_low", char_ready, 0);
        wait_cmd(n);
        check("full_writes", log_q.size(), 15);
        for (int i = 0; i < 15; i++) begin
            check("full_addr", log_q[i].addr, BASE + 32'(8 * i));
            check("full_data", log_q[i].data, 64'h4141_4141_4141_4141);
        end
        release_cmd();

        // grant stall: the per-cycle compare covers hold stability
        log_q.delete();
        gnt_fix = 0;
        tick();
        send_str("XY\n");
        repeat (7) tick();
        check("stall_req", mem_req, 1);
        check("stall_rdy", char_ready, 0);
        gnt_fix = 1;
        wait_cmd(n);
        check("stall_data", log_q[0].data, 64'h5859_0A00_0000_0000);
        release_cmd();

        send_str("Z\n");
        wait_cmd(n);
        n = 0;
        while (printf_cmd && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cmd_cycles", n, TO + 1);
        check("timeout_err", err_timeout, 1);
        check("timeout_idle", busy, 0);

        gnt_fix = 0;
        tick();
        send_str("Q\n");
        check("rstw_in_write", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstw_mem_req", mem_req, 0);
        check("rstw_cmd", printf_cmd, 0);
        check("rstw_busy", busy, 0);
        check("rstw_err", err_timeout, 0);
        check("rstw_rdy", char_ready, 1);
        gnt_fix = 1;
        log_q.delete();
        send_str("A\n");
        wait_cmd(n);
        check("rstw_writes", log_q.size(), 1);
        check("rstw_addr", log_q[0].addr, BASE);
        check("rstw_data", log_q[0].data, 64'h410A_0000_0000_0000);
        release_cmd();

        gnt_rand = 1;
        done_rand = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            n = int'($urandom_range(0, 19));
            c = (n == 0) ? 8'h00 : (n == 1) ? 8'h0A : 8'(8'h61 + $urandom_range(0, 25));
            send_char(c);
        end
        gnt_rand = 0;
        gnt_fix = 1;
        done_rand = 0;
        done_fix = 1;
        repeat (40) tick();
        done_fix = 0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
